// File: rtl/rr_bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package rr_bus_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Tenure counter width; an unlimited hold still keeps a 1-bit saturating count.
    function automatic int hold_cnt_w(input int max_hold);
        int w;
        w = $clog2(max_hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_bus_arbiter_if
    import rr_bus_arbiter_pkg::*;
#(
    parameter int RADIX    = 16,
    parameter int MAX_HOLD = 0,
    parameter int WIDTH    = $clog2(RADIX),
    parameter int HCW      = hold_cnt_w(MAX_HOLD)
);
    logic [RADIX-1:0] req;
    logic             last;
    logic [RADIX-1:0] grant;
    logic [WIDTH-1:0] grant_idx;
    logic             grant_valid;
    logic [HCW-1:0]   hold_cnt;

    modport master (
        output req, last,
        input  grant, grant_idx, grant_valid, hold_cnt
    );

    modport slave (
        input  req, last,
        output grant, grant_idx, grant_valid, hold_cnt
    );
endinterface

// File: rtl/encoder.sv
// Generic one-hot to binary encoder shared across the codebase.
module Encoder #(
    parameter int RADIX = 16,
    parameter int WIDTH = $clog2(RADIX)
) (
    input  logic [RADIX-1:0] i_onehot,
    output logic [WIDTH-1:0] o_idx
);
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < RADIX; i++) begin
            if (i_onehot[i]) begin
                o_idx = o_idx | WIDTH'(i);
            end
        end
    end
endmodule

// File: rtl/rr_priority_pick.sv
// Rotating-priority pick: first set request strictly after i_ptr, wrapping.
module rr_priority_pick #(
    parameter int RADIX = 16,
    parameter int WIDTH = $clog2(RADIX)
) (
    input  logic [RADIX-1:0] i_req,
    input  logic [WIDTH-1:0] i_ptr,
    output logic [RADIX-1:0] o_winner,
    output logic             o_found
);
    logic [WIDTH:0]         w_shift;
    logic [2*RADIX-1:0]     w_rot_dbl;
    logic [2*RADIX-1:0]     w_unrot_dbl;
    logic [RADIX-1:0]       w_rot;
    logic [RADIX-1:0]       w_iso;

    assign w_shift     = {1'b0, i_ptr} + (WIDTH+1)'(1);
    assign w_rot_dbl   = {i_req, i_req} >> w_shift;
    assign w_rot       = w_rot_dbl[RADIX-1:0];
    assign w_iso       = w_rot & (~w_rot + RADIX'(1));
    assign w_unrot_dbl = {w_iso, w_iso} << w_shift;

    // Lower half holds either zero or the same bit as the upper half, so OR is exact.
    assign o_winner = w_unrot_dbl[2*RADIX-1:RADIX] | w_unrot_dbl[RADIX-1:0];
    assign o_found  = |w_rot_dbl;
endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter with grant hold until end-of-transfer and optional tenure cap.
//   state    | meaning
//   ARB_IDLE | no grant outstanding, arbitrate on any request
//   ARB_BUSY | grant held; release on last, dropped req or tenure cap
module rr_bus_arbiter
    import rr_bus_arbiter_pkg::*;
#(
    parameter int RADIX    = 16,
    parameter int WIDTH    = $clog2(RADIX),
    parameter int MAX_HOLD = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    rr_bus_arbiter_if.slave io_bus
);
    localparam int              HCW       = hold_cnt_w(MAX_HOLD);
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [HCW-1:0]  HOLD_SAT  = '1;
    localparam logic [WIDTH-1:0] PTR_RST  = WIDTH'(RADIX - 1);

    arb_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_ptr, w_ptr_nxt;
    logic [RADIX-1:0] r_grant, w_grant_nxt;
    logic [HCW-1:0]   r_hold, w_hold_nxt;

    logic [WIDTH-1:0] w_idx;
    logic [WIDTH-1:0] w_pick_ptr;
    logic [RADIX-1:0] w_winner;
    logic             w_found;
    logic             w_forced;
    logic             w_release;

    Encoder #(.RADIX(RADIX), .WIDTH(WIDTH)) u_enc (
        .i_onehot (r_grant),
        .o_idx    (w_idx)
    );

    // While busy the pick already uses the grantee as pointer, ready for a same-cycle handoff.
    assign w_pick_ptr = (r_state == ARB_BUSY) ? w_idx : r_ptr;

    rr_priority_pick #(.RADIX(RADIX), .WIDTH(WIDTH)) u_pick (
        .i_req    (io_bus.req),
        .i_ptr    (w_pick_ptr),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

    assign w_forced  = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);
    assign w_release = io_bus.last || ((r_grant & io_bus.req) == '0) || w_forced;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= PTR_RST;
            r_grant <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_hold_nxt  = r_hold;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_winner;
                    w_hold_nxt  = '0;
                    w_state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (w_release) begin
                    w_ptr_nxt  = w_idx;
                    w_hold_nxt = '0;
                    if (w_found) begin
                        w_grant_nxt = w_winner;
                    end else begin
                        w_grant_nxt = '0;
                        w_state_nxt = ARB_IDLE;
                    end
                end else if (r_hold != HOLD_SAT) begin
                    w_hold_nxt = r_hold + HCW'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    assign io_bus.grant       = r_grant;
    assign io_bus.grant_idx   = w_idx;
    assign io_bus.grant_valid = |r_grant;
    assign io_bus.hold_cnt    = r_hold;
endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Round-robin arbiter sharing one accelerator resource (weight/feature buffer port or PE-array input bus) among RADIX requesters. It picks one winner with rotating priority and holds the grant until the winner signals end of transfer. It also caps grant tenure at MAX_HOLD cycles. Outputs are a registered one-hot grant and its binary index, so downstream muxes select from either form directly.

## Interface
- RADIX, 16, number of requesters (≥2)
- WIDTH, $clog2(RADIX), width of grant index
- MAX_HOLD, 0, max cycles a grant may be held; 0 = unlimited
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- req  in  RADIX  per-requester request level; held high until its transfer ends
- last  in  1  end-of-transfer from the current grantee; ignored unless grant_valid
- grant  out  RADIX  registered one-hot grant; all zero when idle
- grant_idx  out  WIDTH  binary index of the set bit of grant; 0 when idle
- grant_valid  out  1  high while any grant is active (= |grant)
- hold_cnt  out  WIDTH+? → $clog2(MAX_HOLD+1) (min 1)  cycles current grant has been held, 0 when idle

## Operation
- States: ARB_IDLE, ARB_BUSY.
- Priority pointer ptr (WIDTH bits) holds the index of the last granted requester. Search order starts at ptr+1, modulo RADIX.
- ARB_IDLE: if |req, winner = first set req in search order. Register grant, grant_idx, grant_valid=1, hold_cnt=0. Go to ARB_BUSY. Otherwise stay idle.
- ARB_BUSY releases the grant when any of the following holds:
  - last=1.
  - req[grant_idx]=0, treated as an implicit release.
  - MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1, a forced release.
- On release:
  - ptr ← grant_idx.
  - Re-arbitrate in the same cycle over current req using the new ptr. The releasing requester has lowest priority but may win if it is the only requester.
  - Winner found: the new grant appears next cycle with no bubble, and hold_cnt resets to 0.
  - No winner: go to ARB_IDLE; grant, grant_idx, grant_valid and hold_cnt become 0.
- No release: grant is unchanged and hold_cnt increments, saturating.
- ptr updates only on release, never on an idle cycle.
- A forced release also fires if last arrives in the same cycle; the behaviour is identical.
- Requests appearing or dropping for non-granted requesters have no effect while BUSY.

## Timing
- Reset values:
  - grant=0, grant_idx=0, grant_valid=0, hold_cnt=0.
  - ptr=RADIX-1, so requester 0 has top priority first.
  - state=ARB_IDLE.
- Request latency: req rising in cycle N while idle gives grant in cycle N+1.
- Handoff: last in cycle M gives the next grant in cycle M+1, with zero idle cycles between grantees.
- MAX_HOLD=K: a grant issued at cycle G is dropped or handed off at cycle G+K at the latest.
- Reset asserted mid-grant returns every output to its reset value on the next edge, regardless of last or req.
- grant_idx is encoded from the registered grant, so it is a pure function of registered state.

## Structure
- Shared package: state enum (ARB_IDLE, ARB_BUSY) and a function computing hold counter width from MAX_HOLD.
- Sub-module rr_priority_pick (combinational): inputs req and ptr, outputs a one-hot winner and found. It is implemented as a double-width rotate, a lowest-set-bit isolate, and an unrotate.
- grant_idx comes from the codebase's existing one-hot-to-binary Encoder instantiated with RADIX/WIDTH. There is no duplicate encoder logic.
- The top level holds the FSM, ptr, grant register and hold counter.

## Test plan
- Reset, then req=4'b0000 with RADIX=4 → grant=0, grant_valid=0, grant_idx=0 every cycle.
- req=4'b1011 held, last pulsed each grant cycle → grants 0,1,3,0,1,3; each handoff is 1 cycle after last with no idle gap.
- Only req[2] high, last at cycle 5 → grant stays 4'b0100 through cycle 5 and is re-granted to 2 at cycle 6.
- MAX_HOLD=3, req=4'b0011, last never asserted → grant 0 for 3 cycles, then grant 1 for 3 cycles, then grant 0; hold_cnt runs 0,1,2.
- Grantee 1 drops req without last while req[3]=1 → grant moves to 3 next cycle, and ptr=1 is confirmed by the following arbitration order.
- rst pulsed while grant=4'b1000 and hold_cnt=2 → all outputs 0 next cycle; the next arbitration with req=4'b1111 grants requester 0.
